cfg_chain_loader: RTL

Sequencer between the UART configuration loader and the fabric configuration scan chain. On a fresh, error-free configuration word it holds the fabric in reset and shifts the word serially into the chain MSB-first. It then pulses the chain latch and releases fabric reset. An optional second pass reads the chain back and verifies it before the latch.

---
 rtl/cfg_chain_loader_pkg.sv | 20 ++
 rtl/cfg_chain_loader_if.sv | 49 ++++
 rtl/cfg_chain_loader_sclk_gen.sv | 59 +++++
 rtl/cfg_chain_loader.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/cfg_chain_loader_pkg.sv
// cfg_chain_loader shared types: FSM state encoding and default sizing.
// Optional readback pass is selected by CFG_READBACK_EN.
package cfg_chain_pkg;

  localparam int CFG_WIDTH_DEF = 52;
  localparam int SCLK_DIV_DEF  = 2;
  localparam int RST_HOLD_DEF  = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HOLD,
    ST_SHIFT,
    ST_VERIFY,
    ST_LATCH,
    ST_RELEASE,
    ST_DONE,
    ST_ERROR
  } state_e;

endpackage

// File: rtl/cfg_chain_loader_if.sv
// Bundle between UART loader, scan chain and fabric for cfg_chain_loader.
// chain_sdi is only consumed when CFG_READBACK_EN is defined.
interface cfg_chain_loader_if
  import cfg_chain_pkg::*;
#(
  parameter int CFG_WIDTH = CFG_WIDTH_DEF
);

  logic                 cfg_valid;
  logic [CFG_WIDTH-1:0] cfg_bits;
  logic                 cfg_src_error;
  logic                 chain_sclk;
  logic                 chain_sdo;
  logic                 chain_sdi;
  logic                 chain_latch;
  logic                 fabric_rst;
  logic                 busy;
  logic                 loaded;
  logic                 load_error;

  modport master (
    input  cfg_valid,
    input  cfg_bits,
    input  cfg_src_error,
    input  chain_sdi,
    output chain_sclk,
    output chain_sdo,
    output chain_latch,
    output fabric_rst,
    output busy,
    output loaded,
    output load_error
  );

  modport slave (
    output cfg_valid,
    output cfg_bits,
    output cfg_src_error,
    output chain_sdi,
    input  chain_sclk,
    input  chain_sdo,
    input  chain_latch,
    input  fabric_rst,
    input  busy,
    input  loaded,
    input  load_error
  );

endinterface

// File: rtl/cfg_chain_loader_sclk_gen.sv
// Scan clock generator: bit-period counter, sclk phase and bit index.
// o_rise (sclk rising strobe) exists only with CFG_READBACK_EN.
module cfg_sclk_gen
  import cfg_chain_pkg::*;
#(
  parameter int W = CFG_WIDTH_DEF,
  parameter int D = SCLK_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_keep,
  output logic o_sclk,
  output logic o_bit_done,
  output logic o_pass_done
`ifdef CFG_READBACK_EN
  ,
  output logic o_rise
`endif
);

  localparam int CW = $clog2(2 * D);
  localparam int BW = $clog2(W);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [BW-1:0] r_bit;
  logic          r_sclk;
  logic          w_cnt_end;
  logic          w_bit_end;
  logic          w_run;

  assign w_cnt_end = r_cnt == CW'(2 * D - 1);
  assign w_bit_end = r_bit == BW'(W - 1);
  assign w_run     = i_en & i_keep;
  assign w_cnt_nxt = w_cnt_end ? '0 : r_cnt + 1'b1;

  // sclk is a flop so the chain never sees decode glitches
  always_ff @(posedge clk) begin
    if (rst || !w_run) begin
      r_cnt  <= '0;
      r_bit  <= '0;
      r_sclk <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_sclk <= w_cnt_nxt >= CW'(D);
      if (w_cnt_end)
        r_bit <= w_bit_end ? '0 : r_bit + 1'b1;
    end
  end

  assign o_sclk      = r_sclk;
  assign o_bit_done  = i_en & w_cnt_end;
  assign o_pass_done = o_bit_done & w_bit_end;
`ifdef CFG_READBACK_EN
  assign o_rise      = i_en & (r_cnt == CW'(D - 1));
`endif

endmodule

// File: rtl/cfg_chain_loader.sv
// Loads a config word MSB-first into the fabric scan chain, then latches.
// CFG_READBACK_EN adds a verify pass comparing chain_sdi before latch.
module cfg_chain_loader
  import cfg_chain_pkg::*;
#(
  parameter int CFG_WIDTH = CFG_WIDTH_DEF,
  parameter int SCLK_DIV  = SCLK_DIV_DEF,
  parameter int RST_HOLD  = RST_HOLD_DEF
) (
  input logic clk,
  input logic rst,
  cfg_chain_loader_if.master bus
);

  localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

  state_e               r_state;
  state_e               w_state_nxt;
  logic                 r_vld_d;
  logic [CFG_WIDTH-1:0] r_sh;
  logic [CFG_WIDTH-1:0] w_sh_nxt;
  logic [HW-1:0]        r_hold;
  logic                 r_sdo;
  logic                 r_fab_rst;
  logic                 r_busy;
  logic                 r_loaded;
  logic                 r_err;
  logic                 r_latch;
  logic                 w_edge;
  logic                 w_shifting;
  logic                 w_keep;
  logic                 w_load;
  logic                 w_sclk;
  logic                 w_bit_done;
  logic                 w_pass_done;
`ifdef CFG_READBACK_EN
  logic                 w_rise;
  logic                 w_mis;
`endif

  assign w_edge     = bus.cfg_valid & ~r_vld_d;
  assign w_shifting = (r_state == ST_SHIFT) ||
                      (r_state == ST_VERIFY);
  assign w_keep     = (w_state_nxt == ST_SHIFT) ||
                      (w_state_nxt == ST_VERIFY);
  assign w_load     = (w_state_nxt == ST_HOLD) &&
                      (r_state != ST_HOLD);

  cfg_sclk_gen #(
    .W (CFG_WIDTH),
    .D (SCLK_DIV)
  ) u_sclk (
    .clk         (clk),
    .rst         (rst),
    .i_en        (w_shifting),
    .i_keep      (w_keep),
    .o_sclk      (w_sclk),
    .o_bit_done  (w_bit_done),
    .o_pass_done (w_pass_done)
`ifdef CFG_READBACK_EN
    ,
    .o_rise      (w_rise)
`endif
  );

`ifdef CFG_READBACK_EN
  // r_sh rotates back to the original word, so its MSB is pass-1 bit k
  assign w_mis = (r_state == ST_VERIFY) & w_rise &
                 (bus.chain_sdi != r_sh[CFG_WIDTH-1]);
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_sh_nxt    = r_sh;
    unique case (r_state)
      ST_IDLE:
        if (w_edge)
          w_state_nxt = bus.cfg_src_error ? ST_ERROR : ST_HOLD;
      ST_HOLD:
        if (r_hold == HW'(RST_HOLD - 1))
          w_state_nxt = ST_SHIFT;
      ST_SHIFT:
        if (w_pass_done)
`ifdef CFG_READBACK_EN
          w_state_nxt = ST_VERIFY;
`else
          w_state_nxt = ST_LATCH;
`endif
      ST_VERIFY: begin
        if (w_pass_done)
          w_state_nxt = ST_LATCH;
`ifdef CFG_READBACK_EN
        if (w_mis)
          w_state_nxt = ST_ERROR;
`endif
      end
      ST_LATCH:   w_state_nxt = ST_RELEASE;
      ST_RELEASE: w_state_nxt = ST_DONE;
      ST_DONE:
        if (w_edge)
          w_state_nxt = ST_HOLD;
      ST_ERROR:   w_state_nxt = ST_ERROR;
      default:    w_state_nxt = ST_IDLE;
    endcase
    if (bus.cfg_src_error &&
        (r_state == ST_HOLD || w_shifting))
      w_state_nxt = ST_ERROR;
    if (w_load)
      w_sh_nxt = bus.cfg_bits;
    else if (w_shifting && w_bit_done)
      w_sh_nxt = {r_sh[CFG_WIDTH-2:0], r_sh[CFG_WIDTH-1]};
  end

  // outputs are registered from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_vld_d   <= 1'b0;
      r_sh      <= '0;
      r_hold    <= '0;
      r_sdo     <= 1'b0;
      r_fab_rst <= 1'b1;
      r_busy    <= 1'b0;
      r_loaded  <= 1'b0;
      r_err     <= 1'b0;
      r_latch   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_vld_d   <= bus.cfg_valid;
      r_sh      <= w_sh_nxt;
      r_hold    <= (r_state == ST_HOLD) ? r_hold + 1'b1 : '0;
      r_sdo     <= w_keep & w_sh_nxt[CFG_WIDTH-1];
      r_fab_rst <= w_state_nxt != ST_DONE;
      r_busy    <= w_state_nxt inside {ST_HOLD, ST_SHIFT,
                     ST_VERIFY, ST_LATCH, ST_RELEASE};
      r_loaded  <= w_state_nxt == ST_DONE;
      r_err     <= w_state_nxt == ST_ERROR;
      r_latch   <= w_state_nxt == ST_LATCH;
    end
  end

  assign bus.chain_sclk  = w_sclk;
  assign bus.chain_sdo   = r_sdo;
  assign bus.chain_latch = r_latch;
  assign bus.fabric_rst  = r_fab_rst;
  assign bus.busy        = r_busy;
  assign bus.loaded      = r_loaded;
  assign bus.load_error  = r_err;

endmodule
